// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped cache.
// Byte addresses carry a 2-byte word: bit 0 is dropped, then OFF, IDX, TAG.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  function automatic int unsigned off_w(input int unsigned wpl);
    return $clog2(wpl);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned lines,
                                        input int unsigned wpl);
    return addr_w - 1 - off_w(wpl) - idx_w(lines);
  endfunction

  function automatic logic [31:0] addr_off(input logic [31:0] addr,
                                           input int unsigned wpl);
    return (addr >> 1) & (wpl - 1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr,
                                           input int unsigned lines,
                                           input int unsigned wpl);
    return (addr >> (1 + off_w(wpl))) & (lines - 1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned lines,
                                           input int unsigned wpl);
    return addr >> (1 + off_w(wpl) + idx_w(lines));
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Tag/valid/data storage: combinational read, synchronous word write,
// line validate and flush-all. Only the valid bits are reset.
module dm_cache_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 9,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned OFF_W  = 2,
  parameter int unsigned LINES  = 8,
  parameter int unsigned WPL    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              val_en,
  input  logic [IDX_W-1:0]  val_idx,
  input  logic [TAG_W-1:0]  val_tag,
  input  logic              flush
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES][WPL];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (val_en) begin
      valid[val_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (val_en) begin
      tag_mem[val_idx] <= val_tag;
    end
    if (wr_en) begin
      data_mem[wr_idx][wr_off] <= wr_data;
    end
  end

  always_comb begin
    rd_valid = valid[rd_idx];
    rd_tag   = tag_mem[rd_idx];
    rd_data  = data_mem[rd_idx][rd_off];
  end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with CPU stall
// handshake, multi-word line fill, flush and saturating hit/miss counters.
module dm_cache
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINES  = 8,
  parameter int unsigned WPL    = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned OFF_W = off_w(WPL);
  localparam int unsigned IDX_W = idx_w(LINES);
  localparam int unsigned TAG_W = tag_w(ADDR_W, LINES, WPL);

  state_t             state;
  logic [OFF_W-1:0]   cnt;
  logic [OFF_W-1:0]   cnt_next;
  logic               fill_done;

  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic               hit;
  logic               ack;
  logic               wr_en;
  logic [OFF_W-1:0]   wr_off;
  logic [DATA_W-1:0]  wr_data;
  logic               val_en;
  logic               flush_all;

  always_comb begin
    off      = OFF_W'(addr_off(32'(cpu_addr), WPL));
    idx      = IDX_W'(addr_idx(32'(cpu_addr), LINES, WPL));
    tag      = TAG_W'(addr_tag(32'(cpu_addr), LINES, WPL));
    cnt_next = cnt + 1'b1;
    hit      = rd_valid && (rd_tag == tag);
    ack      = mem_ack && mem_req;
    wr_en    = ack && ((state == FILL) || ((state == WRITE) && hit));
    wr_off   = (state == FILL) ? cnt : off;
    wr_data  = (state == FILL) ? mem_rdata : cpu_wdata;
    val_en   = ack && (state == FILL) && (cnt == '1);
    flush_all = flush && (state == IDLE);
  end

  // Stall must react in the request cycle so read hits complete with zero latency.
  always_comb begin
    cpu_stall = 1'b0;
    case (state)
      IDLE:    cpu_stall = cpu_req && (flush || cpu_wr || !hit);
      FILL:    cpu_stall = 1'b1;
      WRITE:   cpu_stall = !ack;
      default: cpu_stall = 1'b0;
    endcase
  end

  assign cpu_rdata = rd_data;

  dm_cache_array #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .OFF_W  (OFF_W),
    .LINES  (LINES),
    .WPL    (WPL)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_off   (off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_off   (wr_off),
    .wr_data  (wr_data),
    .val_en   (val_en),
    .val_idx  (idx),
    .val_tag  (tag),
    .flush    (flush_all)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fill_done <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          fill_done <= 1'b0;
          if (!flush && cpu_req) begin
            if (cpu_wr) begin
              state     <= WRITE;
              mem_req   <= 1'b1;
              mem_wr    <= 1'b1;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              if (hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
              end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
              end
            end else if (!hit) begin
              state    <= FILL;
              cnt      <= '0;
              mem_req  <= 1'b1;
              mem_wr   <= 1'b0;
              mem_addr <= {tag, idx, {OFF_W{1'b0}}, 1'b0};
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end else if (!fill_done) begin
              // The access that triggered a fill was already counted as a miss.
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end
          end
        end
        FILL: begin
          if (ack) begin
            cnt <= cnt_next;
            if (cnt == '1) begin
              state     <= IDLE;
              mem_req   <= 1'b0;
              fill_done <= 1'b1;
            end else begin
              mem_addr <= {tag, idx, cnt_next, 1'b0};
            end
          end
        end
        WRITE: begin
          if (ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache with a variable-latency memory model whose
// word at byte address a initially holds 16'hC000 | a.
module tb_dm_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        flush;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int          checks = 0;
  int          errors = 0;

  logic [15:0] mem [256];
  int unsigned lat = 1;
  int unsigned wait_cnt = 0;
  logic [15:0] rd_ack_q [$];
  logic [15:0] last_wr_addr = '0;
  int          req_cycles = 0;

  always #5 clk = ~clk;

  dm_cache #(
    .DATA_W (16),
    .ADDR_W (16),
    .LINES  (8),
    .WPL    (4),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  // Ack arrives in the lat-th cycle that mem_req is high for one request.
  assign mem_ack   = mem_req && (wait_cnt == lat - 1);
  assign mem_rdata = mem[mem_addr[8:1]];

  always @(posedge clk) begin
    if (mem_req) begin
      req_cycles <= req_cycles + 1;
      if (mem_ack) begin
        wait_cnt <= 0;
        if (mem_wr) begin
          mem[mem_addr[8:1]] <= mem_wdata;
          last_wr_addr       <= mem_addr;
        end else begin
          rd_ack_q.push_back(mem_addr);
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns with cpu_req dropped just after
  // the completing edge.
  task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output int stalls, output logic [15:0] rdata);
    bit done;
    done   = 1'b0;
    stalls = 0;
    rdata  = '0;
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        done  = 1'b1;
        rdata = cpu_rdata;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;
    if (!done) check("access_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          stalls;
    int          acks;
    int          req_before;
    logic [15:0] rdata;

    for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i << 1);
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_stall", cpu_stall, 0);

    // Cold read miss with single-cycle memory
    lat = 1;
    access(1'b0, 16'h0010, 16'h0, stalls, rdata);
    check("cold_stalls", stalls, 5);
    check("cold_rdata", rdata, 16'hC010);
    check("cold_miss_cnt", miss_cnt, 1);
    check("cold_hit_cnt", hit_cnt, 0);
    check("cold_ack_count", rd_ack_q.size(), 4);
    if (rd_ack_q.size() == 4) begin
      check("cold_addr0", rd_ack_q[0], 16'h0010);
      check("cold_addr1", rd_ack_q[1], 16'h0012);
      check("cold_addr2", rd_ack_q[2], 16'h0014);
      check("cold_addr3", rd_ack_q[3], 16'h0016);
    end

    // Hit on another word of the same line
    req_before = req_cycles;
    access(1'b0, 16'h0014, 16'h0, stalls, rdata);
    check("hit_stalls", stalls, 0);
    check("hit_rdata", rdata, 16'hC014);
    check("hit_cnt1", hit_cnt, 1);
    check("hit_no_mem_req", req_cycles - req_before, 0);

    // Write hit, 3-cycle memory
    lat = 3;
    access(1'b1, 16'h0012, 16'hBEEF, stalls, rdata);
    check("wr_hit_stalls", stalls, 3);
    check("wr_hit_mem_addr", last_wr_addr, 16'h0012);
    check("wr_hit_mem_data", mem[9], 16'hBEEF);
    check("wr_hit_cnt", hit_cnt, 2);
    access(1'b0, 16'h0012, 16'h0, stalls, rdata);
    check("rd_after_wr_stalls", stalls, 0);
    check("rd_after_wr_data", rdata, 16'hBEEF);
    check("rd_after_wr_hit", hit_cnt, 3);

    // Write miss to a conflicting index must not allocate
    access(1'b1, 16'h0090, 16'h1234, stalls, rdata);
    check("wr_miss_stalls", stalls, 3);
    check("wr_miss_mem_addr", last_wr_addr, 16'h0090);
    check("wr_miss_mem_data", mem[72], 16'h1234);
    check("wr_miss_cnt", miss_cnt, 2);
    access(1'b0, 16'h0010, 16'h0, stalls, rdata);
    check("no_alloc_stalls", stalls, 0);
    check("no_alloc_data", rdata, 16'hC010);
    check("no_alloc_hit", hit_cnt, 4);

    // Flush beats a same-cycle request, which then misses and refills
    lat = 1;
    rd_ack_q.delete();
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 16'h0010;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_stall", cpu_stall, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    access(1'b0, 16'h0010, 16'h0, stalls, rdata);
    check("flush_refill_stalls", stalls, 5);
    check("flush_refill_data", rdata, 16'hC010);
    check("flush_miss_cnt", miss_cnt, 3);
    check("flush_hit_cnt", hit_cnt, 4);
    check("flush_refill_acks", rd_ack_q.size(), 4);

    // Reset during the second ack of a fill
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 16'h0020;
    acks = 0;
    for (int i = 0; i < 20 && acks < 2; i++) begin
      @(negedge clk);
      if (mem_ack) acks++;
    end
    check("second_ack_seen", acks, 2);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("rst_fill_mem_req", mem_req, 0);
    check("rst_fill_hit_cnt", hit_cnt, 0);
    check("rst_fill_miss_cnt", miss_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_ack_q.delete();
    @(posedge clk);
    #1;
    access(1'b0, 16'h0020, 16'h0, stalls, rdata);
    check("reread_stalls", stalls, 5);
    check("reread_data", rdata, 16'hC020);
    check("reread_miss_cnt", miss_cnt, 1);
    check("reread_acks", rd_ack_q.size(), 4);
    if (rd_ack_q.size() == 4) begin
      check("reread_addr0", rd_ack_q[0], 16'h0020);
      check("reread_addr3", rd_ack_q[3], 16'h0026);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
